// File: rtl/uart_fifo_bridge_pkg.sv
// Shared types and helpers for the uart FIFO bridge.
// No logic; pointer sizing and TX engine state encodings only.
package uart_fifo_bridge_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    // Bits needed to hold the unsigned value 'value' (0..value inclusive).
    function automatic int GET_WIDTH(input int value);
        int w;
        w = 1;
        while ((1 << w) <= value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Synchronous FIFO, 2^DEPTH_LOG2 entries, combinational head read; level updates one cycle after push/pop.
// Push when full is dropped unless a pop frees the slot in the same cycle; pop when empty is ignored.
module sync_fifo
    import uart_fifo_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int PTR_W = GET_WIDTH(1 << DEPTH_LOG2);

    logic [DATA_WIDTH-1:0] r_mem [1 << DEPTH_LOG2];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic                  w_do_push;
    logic                  w_do_pop;

    // Pointer MSB toggles on each wrap, so equal indices mean full when the MSBs differ.
    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                       (r_wptr[PTR_W-2:0] == r_rptr[PTR_W-2:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign level     = r_wptr - r_rptr;
    assign rdata     = r_mem[r_rptr[PTR_W-2:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PTR_W-2:0]] <= wdata;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Host-side TX/RX byte buffering for the uart; TX byte reaches uart_data_send 1 cycle after entering an empty FIFO.
// Host TX stalls on tx_ready (FIFO full); RX bytes arriving while the RX FIFO is full are dropped and flagged.
module uart_fifo_bridge
    import uart_fifo_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   tx_level,
    output logic [DEPTH_LOG2:0]   rx_level,
    output logic                  tx_idle,
    output logic                  rx_overrun,
    input  logic                  overrun_clear,
    output logic [DATA_WIDTH-1:0] uart_data_in,
    output logic                  uart_data_send,
    input  logic                  uart_data_sent,
    input  logic [DATA_WIDTH-1:0] uart_data_out,
    input  logic                  uart_data_received
);
    tx_state_t             r_state;
    tx_state_t             w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic                  r_overrun;
    logic                  w_tx_pop;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [DATA_WIDTH-1:0] w_tx_rdata;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic [DATA_WIDTH-1:0] w_rx_rdata;
    logic                  w_rx_push;
    logic                  w_rx_pop;
    logic                  w_rx_drop;

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid && !w_tx_full),
        .wdata (tx_data),
        .pop   (w_tx_pop),
        .rdata (w_tx_rdata),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .level (tx_level)
    );

    // A full RX FIFO drops the incoming byte even if the host pops that same cycle.
    assign w_rx_push = uart_data_received && !w_rx_full;
    assign w_rx_drop = uart_data_received && w_rx_full;
    assign w_rx_pop  = rx_ready && !w_rx_empty;

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rx_push),
        .wdata (uart_data_out),
        .pop   (w_rx_pop),
        .rdata (w_rx_rdata),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .level (rx_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_data_in <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tx_pop) r_data_in <= w_tx_rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (uart_data_sent) w_state_nxt = TX_IDLE;
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_rx_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clear) begin
            r_overrun <= 1'b0;
        end
    end

    assign tx_ready       = !w_tx_full;
    assign tx_idle        = (r_state == TX_IDLE) && w_tx_empty;
    assign uart_data_send = (r_state == TX_BUSY);
    assign uart_data_in   = r_data_in;
    assign rx_valid       = !w_rx_empty;
    assign rx_data        = w_rx_empty ? '0 : w_rx_rdata;
    assign rx_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: directed scenarios plus a randomized run against queue-based models.
module tb_uart_fifo_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] tx_level;
    logic [4:0] rx_level;
    logic       tx_idle;
    logic       rx_overrun;
    logic       overrun_clear;
    logic [7:0] uart_data_in;
    logic       uart_data_send;
    logic       uart_data_sent;
    logic [7:0] uart_data_out;
    logic       uart_data_received;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_fifo_bridge #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .tx_level           (tx_level),
        .rx_level           (rx_level),
        .tx_idle            (tx_idle),
        .rx_overrun         (rx_overrun),
        .overrun_clear      (overrun_clear),
        .uart_data_in       (uart_data_in),
        .uart_data_send     (uart_data_send),
        .uart_data_sent     (uart_data_sent),
        .uart_data_out      (uart_data_out),
        .uart_data_received (uart_data_received)
    );

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for the engine to present a byte; ok=0 on timeout.
    task automatic wait_send(output bit ok);
        int k;
        k = 0;
        while (uart_data_send !== 1'b1 && k < 200) begin
            cyc();
            k++;
        end
        ok = (uart_data_send === 1'b1);
    endtask

    task automatic test_single_tx();
        bit held;
        tx_valid = 1'b1; tx_data = 8'hA5;
        cyc();
        tx_valid = 1'b0;
        n_checks++; if (uart_data_send !== 1'b0) $display("FAIL single_send_early: got %b expected 0", uart_data_send); else n_pass++;
        cyc();
        n_checks++; if (uart_data_send !== 1'b1) $display("FAIL single_send: got %b expected 1", uart_data_send); else n_pass++;
        n_checks++; if (uart_data_in !== 8'hA5) $display("FAIL single_data: got %h expected a5", uart_data_in); else n_pass++;
        n_checks++; if (tx_idle !== 1'b0) $display("FAIL single_busy_idle: got %b expected 0", tx_idle); else n_pass++;
        held = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (uart_data_send !== 1'b1 || uart_data_in !== 8'hA5) held = 1'b0;
        end
        n_checks++; if (held !== 1'b1) $display("FAIL single_hold: got %b expected 1", held); else n_pass++;
        uart_data_sent = 1'b1;
        cyc();
        uart_data_sent = 1'b0;
        n_checks++; if (uart_data_send !== 1'b0) $display("FAIL single_send_drop: got %b expected 0", uart_data_send); else n_pass++;
        n_checks++; if (tx_idle !== 1'b1) $display("FAIL single_idle: got %b expected 1", tx_idle); else n_pass++;
    endtask

    task automatic test_tx_burst();
        bit ok;
        for (int i = 0; i < 17; i++) begin
            n_checks++; if (tx_ready !== 1'b1) $display("FAIL burst_ready_%0d: got %b expected 1", i, tx_ready); else n_pass++;
            tx_valid = 1'b1; tx_data = 8'(i);
            cyc();
        end
        tx_valid = 1'b0;
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL burst_full_ready: got %b expected 0", tx_ready); else n_pass++;
        n_checks++; if (tx_level !== 5'd16) $display("FAIL burst_level: got %0d expected 16", tx_level); else n_pass++;
        n_checks++; if (uart_data_in !== 8'h00) $display("FAIL burst_first: got %h expected 00", uart_data_in); else n_pass++;
        for (int i = 0; i < 17; i++) begin
            wait_send(ok);
            n_checks++; if (!ok) $display("FAIL burst_timeout_%0d: got send=%b expected 1", i, uart_data_send); else n_pass++;
            n_checks++; if (uart_data_in !== 8'(i)) $display("FAIL burst_order_%0d: got %h expected %h", i, uart_data_in, 8'(i)); else n_pass++;
            uart_data_sent = 1'b1;
            cyc();
            uart_data_sent = 1'b0;
        end
        cyc(2);
        n_checks++; if (tx_idle !== 1'b1) $display("FAIL burst_idle: got %b expected 1", tx_idle); else n_pass++;
        n_checks++; if (tx_level !== 5'd0) $display("FAIL burst_level_end: got %0d expected 0", tx_level); else n_pass++;
    endtask

    task automatic test_rx_order();
        logic [7:0] exp_rx [3];
        exp_rx = '{8'h11, 8'h22, 8'h33};
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            uart_data_received = 1'b1; uart_data_out = exp_rx[i];
            cyc();
        end
        uart_data_received = 1'b0;
        n_checks++; if (rx_level !== 5'd3) $display("FAIL rx_level3: got %0d expected 3", rx_level); else n_pass++;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL rx_valid: got %b expected 1", rx_valid); else n_pass++;
        cyc(3);
        n_checks++; if (rx_data !== 8'h11) $display("FAIL rx_stable: got %h expected 11", rx_data); else n_pass++;
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (rx_data !== exp_rx[i]) $display("FAIL rx_order_%0d: got %h expected %h", i, rx_data, exp_rx[i]); else n_pass++;
            cyc();
        end
        rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL rx_empty_valid: got %b expected 0", rx_valid); else n_pass++;
    endtask

    task automatic test_rx_overrun();
        logic [7:0] b;
        rx_q.delete();
        rx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            rx_q.push_back(b);
            uart_data_received = 1'b1; uart_data_out = b;
            cyc();
        end
        uart_data_received = 1'b0;
        n_checks++; if (rx_level !== 5'd16) $display("FAIL ovr_fill_level: got %0d expected 16", rx_level); else n_pass++;
        n_checks++; if (rx_overrun !== 1'b0) $display("FAIL ovr_not_yet: got %b expected 0", rx_overrun); else n_pass++;
        uart_data_received = 1'b1; uart_data_out = 8'hEE;
        cyc();
        uart_data_received = 1'b0;
        n_checks++; if (rx_overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", rx_overrun); else n_pass++;
        n_checks++; if (rx_level !== 5'd16) $display("FAIL ovr_level: got %0d expected 16", rx_level); else n_pass++;
        overrun_clear = 1'b1;
        cyc();
        overrun_clear = 1'b0;
        n_checks++; if (rx_overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", rx_overrun); else n_pass++;
        overrun_clear = 1'b1; uart_data_received = 1'b1; uart_data_out = 8'h77;
        cyc();
        overrun_clear = 1'b0; uart_data_received = 1'b0;
        n_checks++; if (rx_overrun !== 1'b1) $display("FAIL ovr_set_wins: got %b expected 1", rx_overrun); else n_pass++;
        overrun_clear = 1'b1;
        cyc();
        overrun_clear = 1'b0;
        // Host pop and arrival in the same cycle while full: arrival still dropped.
        n_checks++; if (rx_data !== rx_q[0]) $display("FAIL ovr_head: got %h expected %h", rx_data, rx_q[0]); else n_pass++;
        rx_ready = 1'b1; uart_data_received = 1'b1; uart_data_out = 8'h55;
        cyc();
        rx_ready = 1'b0; uart_data_received = 1'b0;
        void'(rx_q.pop_front());
        n_checks++; if (rx_overrun !== 1'b1) $display("FAIL ovr_pop_same_cycle: got %b expected 1", rx_overrun); else n_pass++;
        n_checks++; if (rx_level !== 5'd15) $display("FAIL ovr_level15: got %0d expected 15", rx_level); else n_pass++;
        rx_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            b = rx_q.pop_front();
            n_checks++; if (rx_valid !== 1'b1 || rx_data !== b) $display("FAIL ovr_drain_%0d: got %b/%h expected 1/%h", i, rx_valid, rx_data, b); else n_pass++;
            cyc();
        end
        rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL ovr_drain_empty: got %b expected 0", rx_valid); else n_pass++;
    endtask

    // Enters with rx_overrun still set; puts a byte in flight, then asserts reset between clock edges.
    task automatic test_reset();
        tx_valid = 1'b1; tx_data = 8'h3C;
        cyc();
        tx_data = 8'hC3;
        cyc();
        tx_valid = 1'b0;
        uart_data_received = 1'b1; uart_data_out = 8'h99;
        cyc();
        uart_data_received = 1'b0;
        n_checks++; if (uart_data_send !== 1'b1) $display("FAIL rst_pre_send: got %b expected 1", uart_data_send); else n_pass++;
        n_checks++; if (rx_overrun !== 1'b1) $display("FAIL rst_pre_ovr: got %b expected 1", rx_overrun); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready: got %b expected 1", tx_ready); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h expected 00", rx_data); else n_pass++;
        n_checks++; if (tx_level !== 5'd0) $display("FAIL rst_tx_level: got %0d expected 0", tx_level); else n_pass++;
        n_checks++; if (rx_level !== 5'd0) $display("FAIL rst_rx_level: got %0d expected 0", rx_level); else n_pass++;
        n_checks++; if (tx_idle !== 1'b1) $display("FAIL rst_tx_idle: got %b expected 1", tx_idle); else n_pass++;
        n_checks++; if (rx_overrun !== 1'b0) $display("FAIL rst_overrun: got %b expected 0", rx_overrun); else n_pass++;
        n_checks++; if (uart_data_in !== 8'h00) $display("FAIL rst_data_in: got %h expected 00", uart_data_in); else n_pass++;
        n_checks++; if (uart_data_send !== 1'b0) $display("FAIL rst_send: got %b expected 0", uart_data_send); else n_pass++;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        n_checks++; if (tx_idle !== 1'b1 || uart_data_send !== 1'b0) $display("FAIL rst_after: got idle=%b send=%b expected 1/0", tx_idle, uart_data_send); else n_pass++;
    endtask

    task automatic test_wrap();
        int  tx_acc;
        int  rx_inj;
        int  cycles;
        bit  pop_now;
        bit  full_before;
        tx_acc = 0; rx_inj = 0; cycles = 0;
        tx_q.delete(); rx_q.delete();
        while ((tx_acc < 40 || rx_inj < 40 || tx_q.size() != 0 || rx_q.size() != 0) && cycles < 4000) begin
            n_checks++; if (rx_level !== 5'(rx_q.size())) $display("FAIL wrap_rx_level: got %0d expected %0d", rx_level, rx_q.size()); else n_pass++;
            n_checks++; if (rx_valid !== (rx_q.size() != 0)) $display("FAIL wrap_rx_valid: got %b expected %b", rx_valid, rx_q.size() != 0); else n_pass++;
            if (rx_q.size() != 0) begin
                n_checks++; if (rx_data !== rx_q[0]) $display("FAIL wrap_rx_data: got %h expected %h", rx_data, rx_q[0]); else n_pass++;
            end
            n_checks++; if (tx_level > 5'd16) $display("FAIL wrap_tx_level: got %0d expected <=16", tx_level); else n_pass++;

            tx_valid = (tx_acc < 40) && ($urandom_range(0, 1) == 1);
            tx_data  = 8'($urandom);
            if (tx_valid && tx_ready) begin
                tx_q.push_back(tx_data);
                tx_acc++;
            end
            uart_data_sent = 1'b0;
            if (uart_data_send === 1'b1 && $urandom_range(0, 2) == 0) begin
                n_checks++;
                if (tx_q.size() == 0) $display("FAIL wrap_tx_extra: got %h expected no byte", uart_data_in);
                else if (uart_data_in !== tx_q[0]) $display("FAIL wrap_tx_data: got %h expected %h", uart_data_in, tx_q[0]);
                else n_pass++;
                if (tx_q.size() != 0) void'(tx_q.pop_front());
                uart_data_sent = 1'b1;
            end

            rx_ready           = ($urandom_range(0, 1) == 1);
            uart_data_received = (rx_inj < 40) && ($urandom_range(0, 2) == 0);
            uart_data_out      = 8'($urandom);
            pop_now            = rx_ready && (rx_q.size() != 0);
            full_before        = (rx_q.size() == 16);
            if (pop_now) void'(rx_q.pop_front());
            if (uart_data_received) begin
                rx_inj++;
                if (!full_before) rx_q.push_back(uart_data_out);
            end
            cyc();
            cycles++;
        end
        tx_valid = 1'b0; uart_data_sent = 1'b0; rx_ready = 1'b0; uart_data_received = 1'b0;
        cyc(2);
        n_checks++; if (cycles >= 4000) $display("FAIL wrap_timeout: got %0d cycles expected <4000", cycles); else n_pass++;
        n_checks++; if (tx_idle !== 1'b1) $display("FAIL wrap_tx_idle: got %b expected 1", tx_idle); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL wrap_rx_empty: got %b expected 0", rx_valid); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; overrun_clear = 1'b0;
        uart_data_sent = 1'b0; uart_data_out = 8'h00; uart_data_received = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc();
        n_checks++; if (tx_ready !== 1'b1 || tx_idle !== 1'b1) $display("FAIL init_state: got ready=%b idle=%b expected 1/1", tx_ready, tx_idle); else n_pass++;
        test_single_tx();
        test_tx_burst();
        test_rx_order();
        test_rx_overrun();
        test_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
